popcount_accum_seg: RTL and testbench

POPCOUNT_ACCUM_SEG -- requirements
Module: popcount_accum_seg

---
 rtl/popcount_accum_seg.sv | 119 +++++++++++
 tb/tb_popcount_accum_seg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/popcount_accum_seg.sv
// Two-stage popcount pipeline: stage 1 counts set data bits, stage 2 shows or accumulates
// the count and drives a seven-segment digit with a sticky overflow dot.
module popcount_accum_seg #(
    parameter int unsigned DATA_W   = 5,
    parameter bit          SATURATE = 1'b0,
    parameter bit          SEG_INV  = 1'b0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [0:0] {
        StShow  = 1'b0,
        StAccum = 1'b1
    } state_e;

    logic       clk;
    logic       rst;
    logic       mode_in;
    logic [2:0] pop_cnt;

    assign clk     = io_in[0];
    assign rst     = io_in[1];
    assign mode_in = io_in[2];

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            pop_cnt = pop_cnt + 3'(io_in[3+i]);
        end
    end

    // Stage 1: register the count and mode so io_in never reaches io_out combinationally.
    logic [2:0] p_q;
    logic       m_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            m_q <= 1'b0;
        end else begin
            p_q <= pop_cnt;
            m_q <= mode_in;
        end
    end

    // Stage 2 state register.
    state_e     state_q, state_d;
    logic [3:0] v_q, v_d;
    logic       ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StShow;
            v_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: the mode bit alone decides whether we keep accumulating.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StShow:  state_d = m_q ? StAccum : StShow;
            StAccum: state_d = m_q ? StAccum : StShow;
            default: state_d = StShow;
        endcase
    end

    logic [4:0] sum;
    assign sum = {1'b0, v_q} + {2'b00, p_q};

    // Datapath: entering or staying in show, and restarting accumulation, all reload from P.
    always_comb begin
        v_d   = {1'b0, p_q};
        ovf_d = 1'b0;
        if (state_q == StAccum && m_q) begin
            ovf_d = ovf_q;
            if (sum[4]) begin
                ovf_d = 1'b1;
                v_d   = SATURATE ? 4'hF : sum[3:0];
            end else begin
                v_d = sum[3:0];
            end
        end
    end

    logic [6:0] seg_raw;

    always_comb begin
        seg_raw = 7'h00;
        case (v_q)
            4'h0:    seg_raw = 7'h3F;
            4'h1:    seg_raw = 7'h06;
            4'h2:    seg_raw = 7'h5B;
            4'h3:    seg_raw = 7'h4F;
            4'h4:    seg_raw = 7'h66;
            4'h5:    seg_raw = 7'h6D;
            4'h6:    seg_raw = 7'h7D;
            4'h7:    seg_raw = 7'h07;
            4'h8:    seg_raw = 7'h7F;
            4'h9:    seg_raw = 7'h6F;
            4'hA:    seg_raw = 7'h77;
            4'hB:    seg_raw = 7'h7C;
            4'hC:    seg_raw = 7'h39;
            4'hD:    seg_raw = 7'h5E;
            4'hE:    seg_raw = 7'h79;
            4'hF:    seg_raw = 7'h71;
            default: seg_raw = 7'h00;
        endcase
    end

    assign io_out = {ovf_q, SEG_INV ? ~seg_raw : seg_raw};

endmodule

// File: tb/tb_popcount_accum_seg.sv
// Scoreboard bench for popcount_accum_seg: three parameterisations share one stimulus stream.
module tb_popcount_accum_seg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic [4:0] data = '0;
    logic [7:0] io_in;
    logic [7:0] out_a, out_b, out_c;
    int         cyc = 0;

    assign io_in = {data, mode, rst, clk};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    popcount_accum_seg #(.DATA_W(5), .SATURATE(1'b0), .SEG_INV(1'b0)) u_a (
        .io_in(io_in), .io_out(out_a));
    popcount_accum_seg #(.DATA_W(5), .SATURATE(1'b1), .SEG_INV(1'b0)) u_b (
        .io_in(io_in), .io_out(out_b));
    popcount_accum_seg #(.DATA_W(3), .SATURATE(1'b0), .SEG_INV(1'b1)) u_c (
        .io_in(io_in), .io_out(out_c));

    typedef struct {
        int                 due;
        logic [2:0][7:0]    exp;
        bit   [2:0]         en;
        string              name;
    } entry_t;

    entry_t q[$];
    int     checks = 0;
    int     passes = 0;

    // Reference model, one state set per DUT configuration.
    int cfg_w  [3] = '{5, 5, 3};
    bit cfg_sat[3] = '{1'b0, 1'b1, 1'b0};
    bit cfg_inv[3] = '{1'b0, 1'b0, 1'b1};
    int mv     [3] = '{0, 0, 0};
    bit movf   [3] = '{1'b0, 1'b0, 1'b0};
    bit macc   [3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic [6:0] seg_font(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic model_apply(input bit r, input bit m, input logic [4:0] d);
        for (int j = 0; j < 3; j++) begin
            int cnt;
            cnt = 0;
            for (int b = 0; b < cfg_w[j]; b++) if (d[b]) cnt++;
            if (r) begin
                mv[j] = 0; movf[j] = 1'b0; macc[j] = 1'b0;
            end else if (!macc[j] || !m) begin
                mv[j] = cnt; movf[j] = 1'b0; macc[j] = m;
            end else if (mv[j] + cnt > 15) begin
                movf[j] = 1'b1;
                mv[j] = cfg_sat[j] ? 15 : (mv[j] + cnt) % 16;
            end else begin
                mv[j] = mv[j] + cnt;
            end
        end
    endtask

    function automatic logic [7:0] model_out(input int j);
        logic [6:0] s;
        s = seg_font(mv[j]);
        return {movf[j], cfg_inv[j] ? ~s : s};
    endfunction

    task automatic drive(input bit r, input bit m, input logic [4:0] d);
        @(negedge clk);
        rst = r; mode = m; data = d;
        model_apply(r, m, d);
    endtask

    // Directed sample with hand-computed expectations.
    task automatic send(input bit r, input bit m, input logic [4:0] d, input string nm,
                        input bit [2:0] en, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] ec);
        entry_t e;
        drive(r, m, d);
        e.due = cyc + 2; e.exp[0] = ea; e.exp[1] = eb; e.exp[2] = ec; e.en = en; e.name = nm;
        q.push_back(e);
    endtask

    // Sample whose expectations come from the reference model.
    task automatic send_model(input bit m, input logic [4:0] d, input string nm);
        entry_t e;
        drive(1'b0, m, d);
        e.due = cyc + 2; e.en = 3'b111; e.name = nm;
        for (int j = 0; j < 3; j++) e.exp[j] = model_out(j);
        q.push_back(e);
    endtask

    task automatic check(input string nm, input int j, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s dut%0d cycle %0d: got %02h expected %02h", nm, j, cyc, got, exp);
    endtask

    // Monitor: the DUT presents a new digit every edge, so compare whatever is due now.
    always begin
        @(posedge clk);
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            entry_t e;
            e = q.pop_front();
            if (e.due < cyc) begin
                checks++;
                $display("FAIL %s stale entry: due %0d seen at %0d", e.name, e.due, cyc);
            end else begin
                if (e.en[0]) check(e.name, 0, out_a, e.exp[0]);
                if (e.en[1]) check(e.name, 1, out_b, e.exp[1]);
                if (e.en[2]) check(e.name, 2, out_c, e.exp[2]);
            end
        end
    end

    initial begin
        int combos[64];
        int order[32];
        int tmp;
        int k;

        send(1, 0, 5'b00000, "reset0", 3'b111, 8'h3F, 8'h3F, 8'h40);
        send(1, 0, 5'b00000, "reset1", 3'b111, 8'h3F, 8'h3F, 8'h40);
        send(0, 0, 5'b10110, "show_3", 3'b111, 8'h4F, 8'h4F, 8'h24);
        send(0, 0, 5'b11110, "show_4", 3'b111, 8'h66, 8'h66, 8'h24);
        send(0, 1, 5'b11111, "acc_5", 3'b011, 8'h6D, 8'h6D, 8'h00);
        send(0, 1, 5'b11111, "acc_A", 3'b011, 8'h77, 8'h77, 8'h00);
        send(0, 1, 5'b11111, "acc_F", 3'b011, 8'h71, 8'h71, 8'h00);
        send(0, 1, 5'b11111, "acc_ovf", 3'b011, 8'hE6, 8'hF1, 8'h00);
        for (int i = 0; i < 3; i++)
            send(0, 1, 5'b00000, "acc_zero_hold", 3'b011, 8'hE6, 8'hF1, 8'h00);
        send(0, 1, 5'b00001, "ovf_sticky", 3'b011, 8'hED, 8'hF1, 8'h00);
        // This sample's result is overwritten by the reset on the following edge.
        send(0, 1, 5'b00000, "pre_reset", 3'b011, 8'h3F, 8'h3F, 8'h00);
        send(1, 1, 5'b11111, "mid_reset", 3'b111, 8'h3F, 8'h3F, 8'h40);
        send(0, 1, 5'b00011, "post_reset_2", 3'b011, 8'h5B, 8'h5B, 8'h00);
        send(0, 1, 5'b00001, "acc_3", 3'b011, 8'h4F, 8'h4F, 8'h00);
        send(0, 1, 5'b01111, "acc_7", 3'b011, 8'h07, 8'h07, 8'h00);
        send(0, 0, 5'b00001, "back_show_1", 3'b011, 8'h06, 8'h06, 8'h00);
        send(0, 1, 5'b00011, "restart_2", 3'b011, 8'h5B, 8'h5B, 8'h00);
        send(0, 1, 5'b00111, "restart_acc_5", 3'b011, 8'h6D, 8'h6D, 8'h00);
        send(0, 0, 5'b11111, "same_cycle_change", 3'b011, 8'h6D, 8'h6D, 8'h00);
        send(0, 0, 5'b11100, "narrow_inv", 3'b111, 8'h4F, 8'h4F, 8'h79);
        send(0, 0, 5'b00000, "pre_reset2", 3'b111, 8'h3F, 8'h3F, 8'h40);
        send(1, 0, 5'b00000, "reset2", 3'b111, 8'h3F, 8'h3F, 8'h40);

        // All 64 data/mode combinations in shuffled order.
        for (int i = 0; i < 64; i++) combos[i] = i;
        for (int i = 63; i > 0; i--) begin
            k = int'($urandom_range(i, 0));
            tmp = combos[i]; combos[i] = combos[k]; combos[k] = tmp;
        end
        for (int i = 0; i < 64; i++)
            send_model(combos[i][5], combos[i][4:0], "exh_rand");

        // Mode toggles every cycle over all data values.
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            k = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[k]; order[k] = tmp;
        end
        for (int i = 0; i < 32; i++)
            send_model(i[0], order[i][4:0], "exh_toggle");

        // Long accumulation runs to exercise wrap and saturation.
        for (int i = 0; i < 24; i++)
            send_model(1'b1, 5'($urandom), "exh_accum");

        for (int i = 0; i < 6 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
